// File: rtl/switch_input_port.sv
// Switch input port: synchronises the board switches and an enter button, debounces
// the button and latches the switch value per press. Optional irq output: SWITCH_INPUT_PORT_IRQ_EN.
module switch_input_port #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] switches,
    input  logic       button,
    input  logic       enable,
    output logic [3:0] data_out,
    output logic       ready,
`ifdef SWITCH_INPUT_PORT_IRQ_EN
    output logic       irq,
`endif
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0] raw_bits;
    logic [4:0] sync_bits;
    logic [1:0] chain_reg [5];
    logic [3:0] sw_sync;
    logic       btn_sync;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             capture;
    logic             accept;

    logic [3:0] data_reg;
    logic       ready_reg;
    logic       overrun_reg;

    // Two-flop synchroniser per raw input bit: {button, switches[3:0]}
    assign raw_bits = {button, switches};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_sync
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    chain_reg[gi] <= 2'b00;
                end else begin
                    chain_reg[gi] <= {chain_reg[gi][0], raw_bits[gi]};
                end
            end
            assign sync_bits[gi] = chain_reg[gi][1];
        end
    endgenerate

    assign sw_sync  = sync_bits[3:0];
    assign btn_sync = sync_bits[4];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Counter restarts at 0 on every state change and saturates at CNT_MAX
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (btn_sync) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        capture = (state_reg == PRESS_WAIT) && btn_sync && (cnt_reg == CNT_MAX);
        // A capture is taken if the register is free or is being read this cycle
        accept  = capture && (!ready_reg || enable);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_reg    <= 4'h0;
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (capture) begin
            if (accept) begin
                data_reg  <= sw_sync;
                ready_reg <= 1'b1;
                if (enable) begin
                    overrun_reg <= 1'b0;
                end
            end else begin
                overrun_reg <= 1'b1;
            end
        end else if (enable) begin
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end
    end

    assign data_out = data_reg;
    assign ready    = ready_reg;
    assign overrun  = overrun_reg;

`ifdef SWITCH_INPUT_PORT_IRQ_EN
    logic irq_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= accept;
        end
    end

    assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_switch_input_port.sv
// Cycle-by-cycle vector table for switch_input_port (DEBOUNCE_CYCLES=4); expected
// outputs are queued as each row is driven and compared one edge later.
module tb_switch_input_port;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] switches;
    logic       button;
    logic       enable;
    logic [3:0] data_out;
    logic       ready;
    logic       overrun;
`ifdef SWITCH_INPUT_PORT_IRQ_EN
    logic       irq;
`endif

    switch_input_port #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .switches (switches),
        .button   (button),
        .enable   (enable),
        .data_out (data_out),
        .ready    (ready),
`ifdef SWITCH_INPUT_PORT_IRQ_EN
        .irq      (irq),
`endif
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic       btn;
        logic       en;
        logic [3:0] d;
        logic       r;
        logic       o;
        logic       i;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    vec_t exp_cur;
    vec_t async_exp;
    int   applied     = 0;
    int   miscompares = 0;

    task automatic add_seg(input int n, input logic rst, input logic [3:0] sw,
                           input logic btn, input logic en, input logic [3:0] d,
                           input logic r, input logic o, input logic i);
        vec_t v;
        v.rst = rst; v.sw = sw; v.btn = btn; v.en = en;
        v.d = d; v.r = r; v.o = o; v.i = i;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check_outputs(input vec_t e, input string tag);
        logic bad;
        logic irq_act;
        bad = (data_out !== e.d) || (ready !== e.r) || (overrun !== e.o);
`ifdef SWITCH_INPUT_PORT_IRQ_EN
        irq_act = irq;
        bad = bad || (irq !== e.i);
`else
        irq_act = e.i;
`endif
        if (bad) begin
            miscompares++;
            $display("FAIL %s #%0d: got data_out=%h ready=%b overrun=%b irq=%b, want data_out=%h ready=%b overrun=%b irq=%b",
                     tag, applied, data_out, ready, overrun, irq_act, e.d, e.r, e.o, e.i);
        end else begin
            $display("vec %s #%0d: sw=%h btn=%b en=%b -> data_out=%h ready=%b overrun=%b",
                     tag, applied, e.sw, e.btn, e.en, data_out, ready, overrun);
        end
        applied++;
    endtask

    // Scoreboard side: each row's expectation is checked just after the edge it was driven for
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_cur = exp_q.pop_front();
            check_outputs(exp_cur, "row");
        end
    end

    initial begin
        reset    = 1'b1;
        switches = 4'h0;
        button   = 1'b0;
        enable   = 1'b0;

        //       n  rst sw    btn en   d     r  o  i
        add_seg( 2, 1, 4'hA, 0, 0, 4'h0, 0, 0, 0);  // reset with switches=A
        add_seg( 6, 0, 4'hA, 1, 0, 4'h0, 0, 0, 0);  // edges 1-6: not yet
        add_seg( 1, 0, 4'hA, 1, 0, 4'hA, 1, 0, 1);  // edge 7: capture
        add_seg( 1, 0, 4'hA, 0, 1, 4'hA, 0, 0, 0);  // read clears ready
        add_seg( 6, 0, 4'hA, 0, 0, 4'hA, 0, 0, 0);  // release debounce
        add_seg( 3, 0, 4'h5, 1, 0, 4'hA, 0, 0, 0);  // 3-cycle glitch
        add_seg( 5, 0, 4'h5, 0, 0, 4'hA, 0, 0, 0);  // glitch rejected
        add_seg( 6, 0, 4'h3, 1, 0, 4'hA, 0, 0, 0);
        add_seg( 1, 0, 4'h3, 1, 0, 4'h3, 1, 0, 1);  // capture 3
        add_seg( 2, 0, 4'h7, 0, 0, 4'h3, 1, 0, 0);  // release bounce low 2
        add_seg( 5, 0, 4'h7, 1, 0, 4'h3, 1, 0, 0);  // back high: no recapture
        add_seg( 1, 0, 4'h7, 1, 1, 4'h3, 0, 0, 0);  // read
        add_seg( 1, 0, 4'h7, 1, 1, 4'h3, 0, 0, 0);  // enable while ready=0
        add_seg( 1, 0, 4'h7, 1, 0, 4'h3, 0, 0, 0);
        add_seg( 8, 0, 4'h7, 0, 0, 4'h3, 0, 0, 0);  // release to IDLE
        add_seg( 6, 0, 4'h5, 1, 0, 4'h3, 0, 0, 0);
        add_seg( 1, 0, 4'h5, 1, 0, 4'h5, 1, 0, 1);  // capture 5, unread
        add_seg( 8, 0, 4'h5, 0, 0, 4'h5, 1, 0, 0);
        add_seg( 6, 0, 4'h9, 1, 0, 4'h5, 1, 0, 0);
        add_seg( 1, 0, 4'h9, 1, 0, 4'h5, 1, 1, 0);  // 9 discarded: overrun
        add_seg( 1, 0, 4'h9, 1, 1, 4'h5, 0, 0, 0);  // read clears both
        add_seg( 1, 0, 4'h9, 1, 0, 4'h5, 0, 0, 0);
        add_seg( 8, 0, 4'h9, 0, 0, 4'h5, 0, 0, 0);
        add_seg( 6, 0, 4'h2, 1, 0, 4'h5, 0, 0, 0);
        add_seg( 1, 0, 4'h2, 1, 0, 4'h2, 1, 0, 1);  // capture 2
        add_seg( 8, 0, 4'h2, 0, 0, 4'h2, 1, 0, 0);
        add_seg( 6, 0, 4'hF, 1, 0, 4'h2, 1, 0, 0);
        add_seg( 1, 0, 4'hF, 1, 0, 4'h2, 1, 1, 0);  // F discarded
        add_seg( 8, 0, 4'hF, 0, 0, 4'h2, 1, 1, 0);
        add_seg( 6, 0, 4'hC, 1, 0, 4'h2, 1, 1, 0);
        add_seg( 1, 0, 4'hC, 1, 1, 4'hC, 1, 0, 1);  // read in capture cycle
        add_seg( 1, 0, 4'hC, 1, 0, 4'hC, 1, 0, 0);
        add_seg( 1, 0, 4'hC, 0, 1, 4'hC, 0, 0, 0);
        add_seg( 7, 0, 4'hC, 0, 0, 4'hC, 0, 0, 0);
        add_seg( 5, 0, 4'h6, 1, 0, 4'hC, 0, 0, 0);  // into PRESS_WAIT
        add_seg( 2, 1, 4'h6, 1, 0, 4'h0, 0, 0, 0);  // reset mid-debounce
        add_seg( 6, 0, 4'h6, 1, 0, 4'h0, 0, 0, 0);  // fresh debounce
        add_seg( 1, 0, 4'h6, 1, 0, 4'h6, 1, 0, 1);  // capture 6
        add_seg( 1, 0, 4'h6, 1, 0, 4'h6, 1, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clock);
            reset    = vecs[k].rst;
            switches = vecs[k].sw;
            button   = vecs[k].btn;
            enable   = vecs[k].en;
            exp_q.push_back(vecs[k]);
        end
        @(negedge clock);

        // Reset must clear the outputs without waiting for a clock edge
        reset = 1'b1;
        #1;
        async_exp = '{rst: 1'b1, sw: 4'h6, btn: 1'b1, en: 1'b0,
                      d: 4'h0, r: 1'b0, o: 1'b0, i: 1'b0};
        check_outputs(async_exp, "async_reset");

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        applied++;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/switch_input_port.md
Name: switch_input_port

Overview:
- Input-side counterpart of the processor's LED output register.
- Samples the 4 board switches and an "enter" pushbutton, then synchronises and debounces the button.
- On each debounced press, captures the switch value into a holding register and raises a ready flag.
- The processor reads the value with a one-cycle read strobe, which clears the flag.

Parameters:
- DEBOUNCE_CYCLES, 250000, clock cycles the synchronised button must stay stable before a press or release is accepted (10 ms at 25 MHz). Legal range: 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the debounce counter.

Ports:
- clock  input  1  system clock; every register updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- switches  input  4  raw asynchronous switch levels.
- button  input  1  raw asynchronous enter pushbutton, high = pressed.
- enable  input  1  processor read strobe, one cycle, synchronous to clock.
- data_out  output  4  holding register contents, driven directly from a flop.
- ready  output  1  high when data_out holds an unread capture.
- overrun  output  1  sticky flag: a press was discarded because ready was already high.

Behaviour:
- Reset (asynchronous, active-high):
  - All synchroniser flops, counter, data_out, ready and overrun go to 0.
  - FSM goes to IDLE.
  - Reset asserted mid-debounce abandons the press; no capture occurs.
- Synchroniser:
  - switches and button each pass through 2 flops, giving sw_sync[3:0] and btn_sync.
  - Only the synchronised signals feed the logic below.
- FSM states and transitions (cnt is the debounce counter):
  - IDLE: if btn_sync=1, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT:
    - If btn_sync=0, go to IDLE (bounce rejected).
    - Else if cnt==DEBOUNCE_CYCLES-1, perform a capture and go to HELD.
    - Else cnt++.
  - HELD: if btn_sync=0, go to RELEASE_WAIT and set cnt=0. A held button produces exactly one capture.
  - RELEASE_WAIT:
    - If btn_sync=1, go back to HELD.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else cnt++.
- Counter:
  - Counts from 0 to DEBOUNCE_CYCLES-1 and never wraps.
  - Reset to 0 on every state entry.
- Latency: button goes high and stays high before clock edge 1; ready is high after edge DEBOUNCE_CYCLES+3.
  - Edges 1-2: synchroniser.
  - Edge 3: IDLE to PRESS_WAIT.
  - Edge 3+DEBOUNCE_CYCLES: capture.
- Capture cycle, by case:
  - ready=0: data_out <= sw_sync and ready <= 1.
  - ready=1 and enable=0: the new value is discarded, data_out is kept and overrun <= 1.
  - ready=1 and enable=1 in the same cycle: the read consumes the old value; data_out <= sw_sync, ready stays 1, overrun <= 0.
- Read, enable=1 with no capture that cycle:
  - ready <= 0 and overrun <= 0.
  - data_out holds its value; it is valid whenever ready=1.
  - enable while ready=0 has no effect and is legal.

Optional Feature:
- Macro: SWITCH_INPUT_PORT_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit), a registered one-cycle pulse on each accepted capture (the cycle after which ready is set or data_out is refreshed).
  - No pulse on a discarded (overrun) press.
  - Reset value is 0.
- When undefined: the port and its logic are absent and behaviour is otherwise identical.

Test Plan (DEBOUNCE_CYCLES=4 override):
- Reset with switches=4'hA: data_out=0, ready=0, overrun=0. Hold button high from edge 1 -> ready=1 and data_out=4'hA after edge 7, not earlier.
- Button glitch high for 3 cycles, then low -> no capture, ready stays 0, FSM returns to IDLE. Release bounce (low 2 cycles, high 1) while HELD -> no second capture.
- Capture 4'h3, then pulse enable -> ready=0 the next cycle and data_out stays 4'h3. Enable while ready=0 -> no change.
- Capture 4'h5 without reading, release, press again with 4'h9 -> data_out=4'h5, overrun=1. Then enable -> ready=0, overrun=0.
- Enable asserted in the exact capture cycle of 4'hC while ready=1 holding 4'h2 -> data_out=4'hC, ready=1, overrun=0.
- Assert reset mid PRESS_WAIT, deassert, keep button high -> ready=0 during and after reset until a full fresh debounce completes. With SWITCH_INPUT_PORT_IRQ_EN: irq pulses once per accepted capture and never on an overrun discard.
